// File: rtl/led_output_ctrl.sv
// led_output_ctrl
//   Registered LED output stage for NUM_LEDS channels. Each LED is driven
//   OFF / ON / from its individual PWM waveform / from the group waveform,
//   selected by a 2-bit LEDOUT field, with an optional global invert.
//   LEDOUT writes are double-buffered: they apply at once (och=0) or on the
//   next PWM period boundary (och=1). The external active-low output enable
//   is synchronised, blanks the outputs right away and releases them only
//   after a fixed delay.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous reset, active-high
//   ledout_wdata     new LEDOUT value, field [2n+1:2n] controls LED n
//   ledout_wr        one-cycle write strobe for ledout_wdata
//   och              0 = apply write at once, 1 = apply at next period start
//   pwm_period_start one-cycle pulse at the start of each PWM period
//   pwm_individual   per-LED PWM waveforms
//   group_out        group dim/blink waveform
//   invrt            invert all driven LED outputs
//   oe_n             asynchronous output enable, active-low
//   led              registered LED pins
//   ledout_active    LEDOUT value currently in effect
//   update_pending   shadow holds a value not yet applied
//
// OE state machine
//   state    | meaning
//   DISABLED | outputs blanked, waiting for synchronised oe_n low
//   RELEASE  | oe_n low, counting OE_DELAY_CYCLES before driving
//   ENABLED  | outputs driven from decoded LEDOUT
module led_output_ctrl #(
  parameter int NUM_LEDS        = 4,
  parameter int OE_DELAY_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*NUM_LEDS-1:0] ledout_wdata,
  input  logic                  ledout_wr,
  input  logic                  och,
  input  logic                  pwm_period_start,
  input  logic [NUM_LEDS-1:0]   pwm_individual,
  input  logic                  group_out,
  input  logic                  invrt,
  input  logic                  oe_n,
  output logic [NUM_LEDS-1:0]   led,
  output logic [2*NUM_LEDS-1:0] ledout_active,
  output logic                  update_pending
);

  localparam int CW = $clog2(OE_DELAY_CYCLES) + 1;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RELEASE  = 2'd1,
    ENABLED  = 2'd2
  } oe_state_t;

  oe_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  oe_meta_q, oe_sync_q;
  logic [NUM_LEDS-1:0]   led_q, led_d;
  logic [2*NUM_LEDS-1:0] ledout_active_q, ledout_active_d;
  logic [2*NUM_LEDS-1:0] shadow_q, shadow_d;
  logic                  update_pending_q, update_pending_d;
  logic                  drive_en;
  logic [NUM_LEDS-1:0]   decoded;

  // State register, counter, synchroniser and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= DISABLED;
      cnt_q            <= '0;
      oe_meta_q        <= 1'b1;
      oe_sync_q        <= 1'b1;
      led_q            <= '0;
      ledout_active_q  <= '0;
      shadow_q         <= '0;
      update_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      oe_meta_q        <= oe_n;
      oe_sync_q        <= oe_meta_q;
      led_q            <= led_d;
      ledout_active_q  <= ledout_active_d;
      shadow_q         <= shadow_d;
      update_pending_q <= update_pending_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DISABLED: begin
        if (!oe_sync_q) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (oe_sync_q) begin
          state_d = DISABLED;
        end else if (cnt_q == CW'(OE_DELAY_CYCLES - 1)) begin
          state_d = ENABLED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ENABLED: begin
        if (oe_sync_q) state_d = DISABLED;
      end
      default: state_d = DISABLED;
    endcase
  end

  // Output logic: blanking also looks at oe_sync so a deassertion blanks on
  // the same edge the state machine drops back to DISABLED.
  always_comb begin
    drive_en = (state_q == ENABLED) && !oe_sync_q;
  end

  always_comb begin
    decoded = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      unique case (ledout_active_q[2*i +: 2])
        2'b00: decoded[i] = 1'b0;
        2'b01: decoded[i] = 1'b1;
        2'b10: decoded[i] = pwm_individual[i];
        2'b11: decoded[i] = group_out;
        default: decoded[i] = 1'b0;
      endcase
      decoded[i] = decoded[i] ^ invrt;
    end
    led_d = drive_en ? decoded : '0;
  end

  // LEDOUT double buffer; a write always refreshes the shadow, and a write
  // coincident with the boundary takes priority over an older pending value.
  always_comb begin
    ledout_active_d  = ledout_active_q;
    shadow_d         = shadow_q;
    update_pending_d = update_pending_q;
    if (ledout_wr) begin
      shadow_d = ledout_wdata;
      if (!och || pwm_period_start) begin
        ledout_active_d  = ledout_wdata;
        update_pending_d = 1'b0;
      end else begin
        update_pending_d = 1'b1;
      end
    end else if (update_pending_q && (pwm_period_start || !och)) begin
      ledout_active_d  = shadow_q;
      update_pending_d = 1'b0;
    end
  end

  assign led            = led_q;
  assign ledout_active  = ledout_active_q;
  assign update_pending = update_pending_q;

endmodule

// File: tb/tb_led_output_ctrl.sv
module tb_led_output_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   ledout_wdata;
  logic         ledout_wr;
  logic         och;
  logic         pwm_period_start;
  logic [N-1:0] pwm_individual;
  logic         group_out;
  logic         invrt;
  logic         oe_n;
  logic [N-1:0] led;
  logic [7:0]   ledout_active;
  logic         update_pending;

  int tests = 0;
  int fails = 0;

  led_output_ctrl #(.NUM_LEDS(N), .OE_DELAY_CYCLES(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .ledout_wdata     (ledout_wdata),
    .ledout_wr        (ledout_wr),
    .och              (och),
    .pwm_period_start (pwm_period_start),
    .pwm_individual   (pwm_individual),
    .group_out        (group_out),
    .invrt            (invrt),
    .oe_n             (oe_n),
    .led              (led),
    .ledout_active    (ledout_active),
    .update_pending   (update_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ledout_wdata = '0; ledout_wr = 1'b0; och = 1'b0;
    pwm_period_start = 1'b0; pwm_individual = '0; group_out = 1'b0;
    invrt = 1'b0; oe_n = 1'b0;

    // Reset edge
    tick();
    check("rst_led", led, 0);
    check("rst_active", ledout_active, 0);
    check("rst_pending", update_pending, 0);

    // Enable: edge 1 is the first edge sampling oe_n=0 and also writes 0x55
    rst = 1'b0; ledout_wdata = 8'h55; ledout_wr = 1'b1;
    tick();
    ledout_wr = 1'b0;
    check("en_active", ledout_active, 8'h55);
    check("en_blank_e1", led, 0);
    for (int e = 2; e <= 7; e++) begin
      tick();
      check($sformatf("en_blank_e%0d", e), led, 0);
    end
    tick();
    check("en_on_e8", led, 4'b1111);

    // Mode decode, invert, 1-cycle pipeline
    ledout_wdata = 8'hE4; ledout_wr = 1'b1; pwm_individual = 4'b0100; group_out = 1'b1;
    tick();
    ledout_wr = 1'b0;
    check("dec_active", ledout_active, 8'hE4);
    tick();
    check("dec_led", led, 4'b1110);
    invrt = 1'b1;
    tick();
    check("dec_inv", led, 4'b0001);
    invrt = 1'b0; pwm_individual = 4'b0000;
    tick();
    check("dec_pwm0", led, 4'b1010);
    group_out = 1'b0;
    tick();
    check("dec_grp0", led, 4'b0010);

    // Deferred update, last write wins
    ledout_wdata = 8'h00; ledout_wr = 1'b1;
    tick();
    och = 1'b1; ledout_wdata = 8'hFF;
    tick();
    ledout_wr = 1'b0;
    check("def_pend1", update_pending, 1);
    check("def_act1", ledout_active, 8'h00);
    tick();
    ledout_wdata = 8'hAA; ledout_wr = 1'b1;
    tick();
    ledout_wr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("def_pend_hold", update_pending, 1);
      check("def_act_hold", ledout_active, 8'h00);
    end
    pwm_period_start = 1'b1;
    tick();
    pwm_period_start = 1'b0;
    check("def_act_apply", ledout_active, 8'hAA);
    check("def_pend_clr", update_pending, 0);

    // Write coincident with boundary while pending
    ledout_wdata = 8'hFF; ledout_wr = 1'b1;
    tick();
    check("coin_pend", update_pending, 1);
    ledout_wdata = 8'h5A; pwm_period_start = 1'b1;
    tick();
    ledout_wr = 1'b0; pwm_period_start = 1'b0;
    check("coin_act", ledout_active, 8'h5A);
    check("coin_pend_clr", update_pending, 0);

    // och dropping to 0 applies the pending shadow on the next edge
    ledout_wdata = 8'h0F; ledout_wr = 1'b1;
    tick();
    ledout_wr = 1'b0;
    check("och_pend", update_pending, 1);
    check("och_act_old", ledout_active, 8'h5A);
    och = 1'b0;
    tick();
    check("och_act_new", ledout_active, 8'h0F);
    check("och_pend_clr", update_pending, 0);

    // oe_n pulse high for 3 edges while enabled, all LEDs ON
    ledout_wdata = 8'h55; ledout_wr = 1'b1;
    tick();
    ledout_wr = 1'b0;
    tick();
    check("oe_pre", led, 4'b1111);
    oe_n = 1'b1;
    tick();
    check("oe_d1", led, 4'b1111);
    tick();
    check("oe_d2", led, 4'b1111);
    tick();
    check("oe_d3_blank", led, 0);
    check("oe_active_vis", ledout_active, 8'h55);
    oe_n = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("oe_rel_e%0d", e), led, 0);
    end
    tick();
    check("oe_rel_on", led, 4'b1111);

    // Reset during RELEASE with an update pending
    oe_n = 1'b1;
    tick(); tick(); tick();
    check("rr_blank", led, 0);
    oe_n = 1'b0;
    tick(); tick();
    och = 1'b1; ledout_wdata = 8'hFF; ledout_wr = 1'b1;
    tick();
    ledout_wr = 1'b0;
    tick();
    check("rr_pend", update_pending, 1);
    rst = 1'b1;
    tick();
    check("rr_led", led, 0);
    check("rr_active", ledout_active, 0);
    check("rr_pend_clr", update_pending, 0);
    // Edge 1 after reset: boundary with och=1, stale shadow must not apply
    rst = 1'b0; pwm_period_start = 1'b1;
    tick();
    pwm_period_start = 1'b0;
    check("rr_no_shadow", ledout_active, 0);
    check("rr_no_pend", update_pending, 0);
    och = 1'b0; ledout_wdata = 8'h55; ledout_wr = 1'b1;
    tick();
    ledout_wr = 1'b0;
    for (int e = 3; e <= 7; e++) begin
      tick();
      check($sformatf("rr_rel_e%0d", e), led, 0);
    end
    tick();
    check("rr_on_e8", led, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
